datapath_hs: RTL

//  Parametrised successor to the single-cycle CPU datapath. It executes one micro-op per op_valid/op_ready

---
 rtl/datapath_hs_if.sv | 52 +++++
 rtl/datapath_hs.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_hs_if.sv
// datapath_hs_if: bundle of every datapath_hs signal except clock and reset.
//   slave  modport: the datapath itself.
//   master modport: the environment (control FSM, ALU, memory fabric, IRQ sources).
// Signals:
//   op_valid/op_ready/op_ctl       micro-op handshake and packed control word
//   alu_a/alu_b/alu_y/alu_flags    external ALU operands, result and flags
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_ack/mem_rdata    variable-latency memory bus
//   irq_in/irq/irq_id              interrupt requests and prioritised status
//   instr/sr/pc/bus_err            architectural state visible to the control FSM
//
// Handshake semantics: a micro-op transfers on a rising clock edge where
// op_valid && op_ready. A memory transaction is offered while mem_req is high
// (address/data/we stable) and completes on the edge where mem_ack is high;
// mem_rdata is sampled on that same edge.
interface datapath_hs_if #(
    parameter int DATA_W = 16,
    parameter int IRQ_CH = 2
);
    logic              op_valid;
    logic              op_ready;
    logic [20:0]       op_ctl;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic [5:0]        alu_flags;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [IRQ_CH-1:0] irq_in;
    logic              irq;
    logic [2:0]        irq_id;
    logic [15:0]       instr;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] pc;
    logic              bus_err;

    modport slave (
        input  op_valid, op_ctl, alu_y, alu_flags, mem_ack, mem_rdata, irq_in,
        output op_ready, alu_a, alu_b, mem_req, mem_we, mem_addr, mem_wdata,
               irq, irq_id, instr, sr, pc, bus_err
    );

    modport master (
        output op_valid, op_ctl, alu_y, alu_flags, mem_ack, mem_rdata, irq_in,
        input  op_ready, alu_a, alu_b, mem_req, mem_we, mem_addr, mem_wdata,
               irq, irq_id, instr, sr, pc, bus_err
    );
endinterface

// File: rtl/datapath_hs.sv
// datapath_hs: handshaked CPU datapath. Executes one micro-op per
// op_valid/op_ready transfer, performing at most one write and one read on a
// variable-latency memory bus, then commits PC/SR/instr/register updates.
// Also holds a latched, lowest-index-first IRQ controller.
//
// Ports:
//   clock      clock
//   reset      asynchronous, active-low reset
//   bus        datapath_hs_if.slave (all handshake, ALU, memory, IRQ, state signals)
//   dbg_state  current FSM state (0 IDLE, 1 WR, 2 RD)
//
// op_ctl layout (MSB first):
//   [20] reg_write  [19] mem_to_reg  [18] rd_pc      [17] rd_sp
//   [16] use_imm4   [15] set_flags   [14] set_pc     [13:12] pc_src
//   [11] sr_from_mem [10] mem_write  [9:8] wsrc      [7:5] wmode
//   [4]  wr_sp      [3:0] irq_ack
// Register selects come from the instruction register: r1 = instr[11:8],
// r2 = instr[3:0]; the 4-bit immediate is instr[7:4].
module datapath_hs #(
    parameter int                DATA_W   = 16,
    parameter logic [3:0]        SP_IDX   = 4'hD,
    parameter logic [3:0]        IRQ_IDX  = 4'hC,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int                IRQ_CH   = 2,
    parameter int                TIMEOUT  = 0
) (
    input  logic       clock,
    input  logic       reset,
    datapath_hs_if.slave bus,
    output logic [1:0] dbg_state
);
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       rd_pc;
        logic       rd_sp;
        logic       use_imm4;
        logic       set_flags;
        logic       set_pc;
        logic [1:0] pc_src;
        logic       sr_from_mem;
        logic       mem_write;
        logic [1:0] wsrc;
        logic [2:0] wmode;
        logic       wr_sp;
        logic [3:0] irq_ack;
    } ctl_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_t            state;
    ctl_t              ctl_q;
    logic [DATA_W-1:0] rf [16];
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] sr;
    logic [15:0]       instr;
    logic [IRQ_CH-1:0] pending;
    logic [IRQ_CH-1:0] irq_prev;
    logic              bus_err;
    logic [15:0]       to_cnt;

    function automatic logic needs_read(input ctl_t c);
        return c.rd_pc | c.mem_to_reg | c.sr_from_mem;
    endfunction

    // While idle the live control word is decoded so that zero-latency ops can
    // commit on their accept edge; afterwards the latched copy is used.
    // Registers and instr cannot change between accept and commit, so reading
    // them live is the same as sampling them at accept.
    ctl_t       cur;
    logic [3:0] r1;
    logic [3:0] r2;
    logic       accept;
    logic       timed_out;
    logic       last_ack;
    logic       commit;
    logic [DATA_W-1:0] pc_inc;

    assign cur    = (state == S_IDLE) ? ctl_t'(bus.op_ctl) : ctl_q;
    assign r1     = instr[11:8];
    assign r2     = instr[3:0];
    assign pc_inc = pc + ONE;
    assign accept = bus.op_valid && (state == S_IDLE);

    assign timed_out = (TIMEOUT > 0) && (state != S_IDLE) && !bus.mem_ack
                       && (to_cnt == 16'(TIMEOUT - 1));
    assign last_ack  = bus.mem_ack && ((state == S_RD) ||
                       ((state == S_WR) && !needs_read(cur)));
    assign commit    = (accept && !cur.mem_write && !needs_read(cur)) || last_ack;

    // Outputs
    assign bus.op_ready = (state == S_IDLE);
    assign bus.mem_req  = (state != S_IDLE);
    assign bus.mem_we   = (state == S_WR);
    assign bus.alu_a    = rf[r1];
    assign bus.alu_b    = cur.use_imm4 ? {{(DATA_W-4){1'b0}}, instr[7:4]} : rf[r2];
    assign bus.instr    = instr;
    assign bus.sr       = sr;
    assign bus.pc       = pc;
    assign bus.bus_err  = bus_err;
    assign bus.irq      = |pending;
    assign dbg_state    = state;

    always_comb begin
        bus.mem_addr = '0;
        if (state == S_WR)
            bus.mem_addr = rf[cur.wr_sp ? SP_IDX : r1];
        else if (cur.rd_pc)
            bus.mem_addr = pc;
        else
            bus.mem_addr = rf[cur.rd_sp ? SP_IDX : r2];
    end

    always_comb begin
        case (cur.wsrc)
            2'd0:    bus.mem_wdata = rf[r2];
            2'd1:    bus.mem_wdata = pc_inc;
            2'd2:    bus.mem_wdata = pc;
            default: bus.mem_wdata = sr;
        endcase
    end

    always_comb begin
        bus.irq_id = 3'd0;
        for (int i = IRQ_CH - 1; i >= 0; i--)
            if (pending[i]) bus.irq_id = 3'(i);
    end

    // irq_ack only has four bits; channels above 3 are never acknowledged.
    logic [7:0]        ack_ext;
    logic [IRQ_CH-1:0] ack_mask;
    assign ack_ext  = {4'b0000, cur.irq_ack};
    assign ack_mask = commit ? ack_ext[IRQ_CH-1:0] : '0;

    // Commit values, applied only when commit is high.
    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] sr_next;
    logic [15:0]       instr_next;
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        pc_next    = pc;
        sr_next    = sr;
        instr_next = instr;
        wr_en      = 1'b0;
        wr_idx     = r1;
        wr_data    = bus.alu_y;

        if (cur.rd_pc) instr_next = bus.mem_rdata[15:0];

        if (cur.set_flags) begin
            sr_next[2:0] = bus.alu_flags[2:0];
            if (bus.alu_flags[5]) sr_next[4:3] = bus.alu_flags[4:3];
        end
        if (cur.sr_from_mem) sr_next = bus.mem_rdata;

        if (cur.set_pc) begin
            case (cur.pc_src)
                2'd0:    pc_next = pc_inc;
                2'd1:    pc_next = rf[r1];
                2'd2:    pc_next = bus.mem_rdata;
                default: pc_next = rf[IRQ_IDX];
            endcase
        end

        if (cur.reg_write) begin
            case (cur.wmode)
                3'd0: begin
                    wr_en   = 1'b1;
                    wr_idx  = r1;
                    wr_data = cur.mem_to_reg ? bus.mem_rdata : bus.alu_y;
                end
                3'd1: begin wr_en = 1'b1; wr_idx = r1;     wr_data = rf[r1] - ONE;     end
                3'd2: begin wr_en = 1'b1; wr_idx = r2;     wr_data = rf[r2] + ONE;     end
                3'd3: begin wr_en = 1'b1; wr_idx = SP_IDX; wr_data = rf[SP_IDX] - ONE; end
                3'd4: begin wr_en = 1'b1; wr_idx = SP_IDX; wr_data = rf[SP_IDX] + ONE; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ctl_q    <= '0;
            pc       <= RESET_PC;
            sr       <= '0;
            instr    <= '0;
            pending  <= '0;
            irq_prev <= '0;
            bus_err  <= 1'b0;
            to_cnt   <= '0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            // A new rising edge beats an acknowledge landing on the same edge.
            irq_prev <= bus.irq_in;
            pending  <= (pending & ~ack_mask) | (bus.irq_in & ~irq_prev);

            if (commit) begin
                pc    <= pc_next;
                sr    <= sr_next;
                instr <= instr_next;
                if (wr_en) rf[wr_idx] <= wr_data;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ctl_q  <= ctl_t'(bus.op_ctl);
                        to_cnt <= '0;
                        if (cur.mem_write)      state <= S_WR;
                        else if (needs_read(cur)) state <= S_RD;
                    end
                end
                S_WR, S_RD: begin
                    if (bus.mem_ack) begin
                        to_cnt <= '0;
                        state  <= (state == S_WR && needs_read(ctl_q)) ? S_RD : S_IDLE;
                    end else if (timed_out) begin
                        // Abandon the whole op: nothing was committed yet.
                        bus_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
